// File: rtl/st_frame_pkg.sv
// Shared types for the stream-to-frame-memory writer.
// Holds the capture FSM state encoding, which is also visible on the debug state port.
package st_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_SOP = 2'd1,
      ST_WRITE    = 2'd2,
      ST_DONE     = 2'd3
   } st_state_e;

endpackage

// File: rtl/st_frame_writer_if.sv
// Avalon-ST pixel stream between a source and the frame writer sink.
// Handshake: a beat transfers on every clock edge where snk_valid_i and snk_ready_o are
// both high (readyLatency 0); the source holds data/sop/eop stable while valid waits on ready.
interface st_frame_writer_if #(
   parameter int WORD = 8
);
   logic [WORD-1:0] snk_data_i;
   logic            snk_valid_i;
   logic            snk_sop_i;
   logic            snk_eop_i;
   logic            snk_ready_o;

   modport master (
      output snk_data_i,
      output snk_valid_i,
      output snk_sop_i,
      output snk_eop_i,
      input  snk_ready_o
   );

   modport slave (
      input  snk_data_i,
      input  snk_valid_i,
      input  snk_sop_i,
      input  snk_eop_i,
      output snk_ready_o
   );
endinterface

// File: rtl/st_frame_writer.sv
// Captures one armed frame from an Avalon-ST sink straight into the frame memory write port.
// Optional sop/eop framing checks and the sticky error flag are enabled by ST_PACKET_CHECK_EN.
module st_frame_writer
   import st_frame_pkg::*;
#(
   parameter  int WORD     = 8,
   parameter  int SIZE     = 256,
   localparam int ADR_SIZE = $clog2(SIZE)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                start_i,
   st_frame_writer_if.slave    snk,
   output logic                mem_wr_o,
   output logic                mem_clear_o,
   output logic [ADR_SIZE-1:0] mem_adr_o,
   output logic [WORD-1:0]     mem_data_o,
   output logic                busy_o,
   output logic                done_o,
   output logic [ADR_SIZE:0]   count_o,
   output logic                err_o,
   output st_state_e           dbg_state_o
);

   localparam logic [ADR_SIZE:0] COUNT_FULL = SIZE[ADR_SIZE:0];

   st_state_e         state_q;
   logic [ADR_SIZE:0] count_q;
   logic              err_q;

   logic              in_wait_sop;
   logic              in_write;
   logic              accept;
   logic              is_discard;
   logic              is_restart;
   logic              frame_end;
   logic              overflow;
   logic              err_set;
   logic [ADR_SIZE:0] wr_count;

   assign in_wait_sop = (state_q == ST_WAIT_SOP);
   assign in_write    = (state_q == ST_WRITE);
   assign accept      = snk.snk_valid_i & snk.snk_ready_o;

`ifdef ST_PACKET_CHECK_EN
   assign is_discard = in_wait_sop & ~snk.snk_sop_i;
   assign is_restart = in_write & snk.snk_sop_i;
   assign err_set    = accept & (is_discard | is_restart | (mem_wr_o & overflow));
`else
   // Without framing checks the first beat opens the frame and sop is plain data.
   assign is_discard = 1'b0;
   assign is_restart = 1'b0;
   assign err_set    = 1'b0;
`endif

   // Count after the current beat lands; a frame opening or restart always lands at address 0.
   assign wr_count  = (in_wait_sop | is_restart) ? {{ADR_SIZE{1'b0}}, 1'b1}
                                                 : count_q + 1'b1;
   assign overflow  = ~snk.snk_eop_i & (wr_count == COUNT_FULL);
   assign frame_end = snk.snk_eop_i | (wr_count == COUNT_FULL);

   assign snk.snk_ready_o = in_wait_sop | in_write;
   assign mem_wr_o        = accept & ~is_discard;
   assign mem_clear_o     = (state_q == ST_IDLE) & start_i;
   assign mem_adr_o       = (in_write & ~is_restart) ? count_q[ADR_SIZE-1:0] : '0;
   assign mem_data_o      = snk.snk_data_i;
   assign busy_o          = in_wait_sop | in_write;
   assign done_o          = (state_q == ST_DONE);
   assign count_o         = count_q;
   assign err_o           = err_q;
   assign dbg_state_o     = state_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  count_q <= '0;
                  err_q   <= 1'b0;
                  state_q <= ST_WAIT_SOP;
               end
            end
            ST_WAIT_SOP, ST_WRITE: begin
               if (err_set) begin
                  err_q <= 1'b1;
               end
               if (mem_wr_o) begin
                  count_q <= wr_count;
                  state_q <= frame_end ? ST_DONE : ST_WRITE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_st_frame_writer.sv
// Directed bench for st_frame_writer with SIZE=4; expectations follow ST_PACKET_CHECK_EN.
module tb_st_frame_writer;
   import st_frame_pkg::*;

   localparam int WORD = 8;
   localparam int SIZE = 4;
   localparam int ADR_SIZE = $clog2(SIZE);
`ifdef ST_PACKET_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic                clk;
   logic                rst_n;
   logic                start;
   logic                mem_wr;
   logic                mem_clear;
   logic [ADR_SIZE-1:0] mem_adr;
   logic [WORD-1:0]     mem_data;
   logic                busy;
   logic                done;
   logic [ADR_SIZE:0]   count;
   logic                err;
   st_state_e           dbg_state;

   int passed = 0;
   int total  = 0;

   st_frame_writer_if #(.WORD(WORD)) snk ();

   st_frame_writer #(.WORD(WORD), .SIZE(SIZE)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .start_i     (start),
      .snk         (snk),
      .mem_wr_o    (mem_wr),
      .mem_clear_o (mem_clear),
      .mem_adr_o   (mem_adr),
      .mem_data_o  (mem_data),
      .busy_o      (busy),
      .done_o      (done),
      .count_o     (count),
      .err_o       (err),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one stream cycle, then let combinational outputs settle.
   task automatic drive(input logic v, input logic [WORD-1:0] d, input logic sop, input logic eop);
      snk.snk_valid_i = v;
      snk.snk_data_i  = d;
      snk.snk_sop_i   = sop;
      snk.snk_eop_i   = eop;
      #1;
   endtask

   task automatic start_frame();
      start = 1'b1;
      #1;
      chk("clear_on_start", mem_clear, 1);
      tick();
      start = 1'b0;
      #1;
   endtask

   task automatic write_beat(input string tag, input logic [WORD-1:0] d, input logic sop,
                             input logic eop, input logic [ADR_SIZE-1:0] adr);
      drive(1'b1, d, sop, eop);
      chk({tag, "_wr"}, mem_wr, 1);
      chk({tag, "_adr"}, mem_adr, adr);
      chk({tag, "_data"}, mem_data, d);
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      snk.snk_valid_i = 1'b0;
      snk.snk_data_i  = '0;
      snk.snk_sop_i   = 1'b0;
      snk.snk_eop_i   = 1'b0;
      #2;
      chk("rst_ready", snk.snk_ready_o, 0);
      chk("rst_wr", mem_wr, 0);
      chk("rst_clear", mem_clear, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_err", err, 0);
      chk("rst_adr", mem_adr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Normal frame: 0x11(sop) 0x22 0x33(eop)
      start_frame();
      chk("norm_busy", busy, 1);
      chk("norm_ready", snk.snk_ready_o, 1);
      write_beat("norm0", 8'h11, 1'b1, 1'b0, 2'd0);
      write_beat("norm1", 8'h22, 1'b0, 1'b0, 2'd1);
      write_beat("norm2", 8'h33, 1'b0, 1'b1, 2'd2);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("norm_done", done, 1);
      chk("norm_count", count, 3);
      chk("norm_err", err, 0);
      chk("norm_ready_done", snk.snk_ready_o, 0);
      tick();
      chk("norm_done_clr", done, 0);
      chk("norm_count_hold", count, 3);

      // Gaps between beats
      start_frame();
      write_beat("gap0", 8'hA0, 1'b1, 1'b0, 2'd0);
      drive(1'b0, 8'h5A, 1'b0, 1'b0);
      chk("gap_idle0_wr", mem_wr, 0);
      tick();
      write_beat("gap1", 8'hA1, 1'b0, 1'b0, 2'd1);
      drive(1'b0, 8'h5B, 1'b0, 1'b0);
      chk("gap_idle1_wr", mem_wr, 0);
      tick();
      write_beat("gap2", 8'hA2, 1'b0, 1'b0, 2'd2);
      drive(1'b0, 8'h5C, 1'b0, 1'b0);
      chk("gap_idle2_wr", mem_wr, 0);
      tick();
      write_beat("gap3", 8'hA3, 1'b0, 1'b1, 2'd3);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("gap_done", done, 1);
      chk("gap_count", count, 4);
      chk("gap_err", err, 0);
      tick();

      // Overflow: five beats, no eop
      start_frame();
      write_beat("ovf0", 8'hB0, 1'b1, 1'b0, 2'd0);
      write_beat("ovf1", 8'hB1, 1'b0, 1'b0, 2'd1);
      write_beat("ovf2", 8'hB2, 1'b0, 1'b0, 2'd2);
      write_beat("ovf3", 8'hB3, 1'b0, 1'b0, 2'd3);
      drive(1'b1, 8'hB4, 1'b0, 1'b0);
      chk("ovf_done", done, 1);
      chk("ovf_count", count, 4);
      chk("ovf_err", err, CHK);
      chk("ovf_ready", snk.snk_ready_o, 0);
      chk("ovf_wr5", mem_wr, 0);
      tick();
      chk("ovf_idle_ready", snk.snk_ready_o, 0);
      chk("ovf_idle_wr", mem_wr, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // Missing sop: 0xAA then 0xBB(sop,eop)
      start_frame();
      chk("msop_err_clr", err, 0);
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("msop_aa_wr", mem_wr, !CHK);
      chk("msop_aa_adr", mem_adr, 0);
      tick();
      write_beat("msop_bb", 8'hBB, 1'b1, 1'b1, CHK ? 2'd0 : 2'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("msop_done", done, 1);
      chk("msop_count", count, CHK ? 1 : 2);
      chk("msop_err", err, CHK);
      tick();

      // sop in the middle of a frame
      start_frame();
      write_beat("rst0", 8'hC0, 1'b1, 1'b0, 2'd0);
      write_beat("rst1", 8'hC1, 1'b1, 1'b0, CHK ? 2'd0 : 2'd1);
      write_beat("rst2", 8'hC2, 1'b0, 1'b1, CHK ? 2'd1 : 2'd2);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("restart_done", done, 1);
      chk("restart_count", count, CHK ? 2 : 3);
      chk("restart_err", err, CHK);
      tick();

      // Reset in the middle of a frame
      start_frame();
      write_beat("mid0", 8'hD0, 1'b1, 1'b0, 2'd0);
      write_beat("mid1", 8'hD1, 1'b0, 1'b0, 2'd1);
      drive(1'b1, 8'hD2, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid_ready", snk.snk_ready_o, 0);
      chk("mid_wr", mem_wr, 0);
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_count", count, 0);
      chk("mid_adr", mem_adr, 0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      chk("mid_no_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      start_frame();
      write_beat("post_rst", 8'hE0, 1'b1, 1'b1, 2'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_rst_done", done, 1);
      chk("post_rst_count", count, 1);

      // start held through DONE is picked up in IDLE
      start = 1'b1;
      #1;
      chk("b2b_no_clear_done", mem_clear, 0);
      tick();
      chk("b2b_clear_idle", mem_clear, 1);
      chk("b2b_count_hold", count, 1);
      tick();
      start = 1'b0;
      #1;
      chk("b2b_busy", busy, 1);
      chk("b2b_count_zero", count, 0);
      write_beat("b2b", 8'hF0, 1'b1, 1'b1, 2'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("b2b_done", done, 1);
      tick();
      chk("b2b_state_idle", dbg_state, ST_IDLE);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
